// File: rtl/inta_sequencer.sv
// INTA sequencer for an 8259-style PIC in 8086 mode.
// Raises INT, tracks the two INTA pulses, freezes the winning IR,
// drives the cascade bus as master and places the vector on the data bus.
//
// state | meaning
// IDLE  | no request being served
// PEND  | INT raised, waiting for the first INTA fall
// ACK1  | first INTA low, id frozen, cascade driven if a slave owns the IR
// WAIT2 | between the two INTA pulses
// ACK2  | second INTA low, vector driven by whichever device is responsible
module inta_sequencer #(
    parameter int SYNC_STAGES = 2          // 1..3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       INTA_n,
    input  logic       SNGL,
    input  logic       SP,
    input  logic       AEOI,
    input  logic [7:0] slaveReg,
    input  logic [2:0] slaveID,
    input  logic [4:0] vecBase,
    input  logic       intrFlag,
    input  logic [2:0] intrID,
    input  logic [2:0] cascIn,
    output logic [2:0] cascOut,
    output logic       cascOE,
    output logic       INT,
    output logic [7:0] isrSet,
    output logic [7:0] eoiAuto,
    output logic [7:0] dataOut,
    output logic       dataOE,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} stateT;

    stateT                  state, stateNext;
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   intaS, intaD, fall, rise;
    logic [2:0]             idQ, idNext;
    logic                   spuriousQ, spuriousNext;
    logic                   responsible;
    logic                   intNext, cascOENext, dataOENext;
    logic [2:0]             cascOutNext;
    logic [7:0]             isrSetNext, eoiAutoNext, dataOutNext;

    assign intaS = syncQ[SYNC_STAGES-1];
    assign fall  = intaD & ~intaS;
    assign rise  = ~intaD & intaS;
    assign busy  = (state != IDLE);

    // The slave's decision uses cascIn as seen on the second fall edge.
    assign responsible = SNGL ? 1'b1 : (SP ? ~slaveReg[idQ] : (cascIn == slaveID));

    // Synchronise INTA_n; flops idle high so reset looks like INTA inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncQ <= '1;
            intaD <= 1'b1;
        end else begin
            syncQ[0] <= INTA_n;
            for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
            intaD <= intaS;
        end
    end

    // State, frozen id and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idQ       <= '0;
            spuriousQ <= 1'b0;
            INT       <= 1'b0;
            cascOut   <= '0;
            cascOE    <= 1'b0;
            isrSet    <= '0;
            eoiAuto   <= '0;
            dataOut   <= '0;
            dataOE    <= 1'b0;
        end else begin
            state     <= stateNext;
            idQ       <= idNext;
            spuriousQ <= spuriousNext;
            INT       <= intNext;
            cascOut   <= cascOutNext;
            cascOE    <= cascOENext;
            isrSet    <= isrSetNext;
            eoiAuto   <= eoiAutoNext;
            dataOut   <= dataOutNext;
            dataOE    <= dataOENext;
        end
    end

    // Next-state and next-output decode; pulses default low every cycle.
    always_comb begin
        stateNext    = state;
        idNext       = idQ;
        spuriousNext = spuriousQ;
        intNext      = INT;
        cascOutNext  = cascOut;
        cascOENext   = cascOE;
        isrSetNext   = '0;
        eoiAutoNext  = '0;
        dataOutNext  = dataOut;
        dataOENext   = dataOE;
        case (state)
            IDLE: begin
                if (intrFlag) begin
                    stateNext = PEND;
                    intNext   = 1'b1;
                end
            end
            PEND: begin
                if (fall) begin
                    stateNext = ACK1;
                    intNext   = 1'b0;
                    if (intrFlag) begin
                        idNext       = intrID;
                        spuriousNext = 1'b0;
                        isrSetNext   = 8'b1 << intrID;
                    end else begin
                        // Request withdrawn before acknowledge: answer with IR7.
                        idNext       = 3'd7;
                        spuriousNext = 1'b1;
                    end
                    if (SP && !SNGL && slaveReg[idNext]) begin
                        cascOutNext = idNext;
                        cascOENext  = 1'b1;
                    end else begin
                        cascOutNext = '0;
                        cascOENext  = 1'b0;
                    end
                end
            end
            ACK1: begin
                if (rise) stateNext = WAIT2;
            end
            WAIT2: begin
                if (fall) begin
                    stateNext   = ACK2;
                    cascOutNext = '0;
                    cascOENext  = 1'b0;
                    if (responsible) begin
                        dataOutNext = {vecBase, idQ};
                        dataOENext  = 1'b1;
                    end
                end
            end
            ACK2: begin
                if (rise) begin
                    stateNext   = IDLE;
                    dataOutNext = '0;
                    dataOENext  = 1'b0;
                    cascOutNext = '0;
                    cascOENext  = 1'b0;
                    if (AEOI && !spuriousQ) eoiAutoNext = 8'b1 << idQ;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: reset values, a table of directed transactions,
// randomized transactions against a transaction-level model, and hand-written
// sequences for the IDLE pulse, unserved slave and mid-sequence reset.
module tb_inta_sequencer;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       INTA_n, SNGL, SP, AEOI, intrFlag;
    logic [7:0] slaveReg;
    logic [2:0] slaveID, intrID, cascIn;
    logic [4:0] vecBase;
    logic [2:0] cascOut;
    logic       cascOE, INT, dataOE, busy;
    logic [7:0] isrSet, eoiAuto, dataOut;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic       sngl, sp, aeoi;
        logic [7:0] slaveReg;
        logic [2:0] slaveID;
        logic [4:0] vecBase;
        logic [2:0] cascIn;
        logic       flag;
        logic [2:0] id;
        logic [7:0] eIsr;
        logic       eCascOE;
        logic [2:0] eCascOut;
        logic       eDataOE;
        logic [7:0] eData;
        logic [7:0] eEoi;
    } vec_t;

    vec_t vecs[8];

    // Observations gathered across a transaction.
    logic [7:0] isrOr, eoiOr, dataSeen;
    logic [2:0] cascSeen;
    int         isrCnt, eoiCnt, dataOECnt, cascOECnt, strayCnt, busyCnt, intCnt;

    always #5 clk = ~clk;

    inta_sequencer #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .INTA_n(INTA_n), .SNGL(SNGL), .SP(SP), .AEOI(AEOI),
        .slaveReg(slaveReg), .slaveID(slaveID), .vecBase(vecBase), .intrFlag(intrFlag),
        .intrID(intrID), .cascIn(cascIn), .cascOut(cascOut), .cascOE(cascOE), .INT(INT),
        .isrSet(isrSet), .eoiAuto(eoiAuto), .dataOut(dataOut), .dataOE(dataOE), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mkVec(input logic sngl, input logic sp, input logic aeoi,
                                   input logic [7:0] sr, input logic [2:0] sid,
                                   input logic [4:0] vb, input logic [2:0] ci,
                                   input logic flag, input logic [2:0] id,
                                   input logic [7:0] eIsr, input logic eCascOE,
                                   input logic [2:0] eCascOut, input logic eDataOE,
                                   input logic [7:0] eData, input logic [7:0] eEoi);
        vec_t v;
        v.sngl = sngl; v.sp = sp; v.aeoi = aeoi; v.slaveReg = sr; v.slaveID = sid;
        v.vecBase = vb; v.cascIn = ci; v.flag = flag; v.id = id;
        v.eIsr = eIsr; v.eCascOE = eCascOE; v.eCascOut = eCascOut;
        v.eDataOE = eDataOE; v.eData = eData; v.eEoi = eEoi;
        return v;
    endfunction

    // Transaction-level reference: what one whole acknowledge cycle should show.
    function automatic vec_t predict(input vec_t v);
        vec_t       r;
        logic [2:0] servedId;
        logic       resp;
        r = v;
        servedId   = v.flag ? v.id : 3'd7;
        r.eIsr     = v.flag ? (8'd1 << v.id) : 8'd0;
        r.eCascOE  = !v.sngl && v.sp && v.slaveReg[servedId];
        r.eCascOut = r.eCascOE ? servedId : 3'd0;
        if (v.sngl)    resp = 1'b1;
        else if (v.sp) resp = !v.slaveReg[servedId];
        else           resp = (v.cascIn == v.slaveID);
        r.eDataOE  = resp;
        r.eData    = resp ? {v.vecBase, servedId} : 8'd0;
        r.eEoi     = (v.aeoi && v.flag) ? (8'd1 << servedId) : 8'd0;
        return r;
    endfunction

    task automatic clearObs();
        isrOr = 0; eoiOr = 0; dataSeen = 0; cascSeen = 0;
        isrCnt = 0; eoiCnt = 0; dataOECnt = 0; cascOECnt = 0; strayCnt = 0;
        busyCnt = 0; intCnt = 0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            isrOr |= isrSet;
            eoiOr |= eoiAuto;
            if (isrSet != 0)  isrCnt++;
            if (eoiAuto != 0) eoiCnt++;
            if (dataOE) begin dataOECnt++; dataSeen |= dataOut; end
            if (cascOE) begin cascOECnt++; cascSeen |= cascOut; end
            else if (cascOut != 0) strayCnt++;
            if (busy) busyCnt++;
            if (INT)  intCnt++;
        end
    endtask

    task automatic doTxn(input vec_t v, input bit keepFlag);
        SNGL = v.sngl; SP = v.sp; AEOI = v.aeoi; slaveReg = v.slaveReg;
        slaveID = v.slaveID; vecBase = v.vecBase; cascIn = v.cascIn;
        INTA_n = 1'b1; intrFlag = 1'b0;
        step(2);
        check("idle before request", {30'd0, busy, INT}, 32'd0);
        clearObs();
        intrFlag = 1'b1; intrID = v.id;
        step(1);
        check("INT one cycle after intrFlag", INT, 1);
        if (!v.flag) intrFlag = 1'b0;
        step(1);
        INTA_n = 1'b0;
        step($urandom_range(1, 3));
        INTA_n = 1'b1;
        step(SYNC + 2 + $urandom_range(0, 2));
        // id is frozen by now; a new intrID must not matter.
        if (v.flag) intrID = 3'($urandom);
        INTA_n = 1'b0;
        if (!keepFlag) intrFlag = 1'b0;
        step($urandom_range(1, 3));
        INTA_n = 1'b1;
        step(SYNC + 4);
    endtask

    task automatic checkTxn(input vec_t e, input string tag, input bit keepFlag);
        check($sformatf("%s isrSet", tag), isrOr, e.eIsr);
        check($sformatf("%s isrSet width", tag), isrCnt, (e.eIsr != 0) ? 1 : 0);
        check($sformatf("%s cascOE", tag), cascOECnt != 0, e.eCascOE);
        if (e.eCascOE) check($sformatf("%s cascOut", tag), cascSeen, e.eCascOut);
        check($sformatf("%s cascOut without OE", tag), strayCnt, 0);
        check($sformatf("%s dataOE", tag), dataOECnt != 0, e.eDataOE);
        if (e.eDataOE) check($sformatf("%s dataOut", tag), dataSeen, e.eData);
        check($sformatf("%s eoiAuto", tag), eoiOr, e.eEoi);
        check($sformatf("%s eoiAuto width", tag), eoiCnt, (e.eEoi != 0) ? 1 : 0);
        check($sformatf("%s end outputs", tag), {dataOut, dataOE, cascOE, 3'd0, cascOut}, 0);
        if (keepFlag) check($sformatf("%s INT re-raised", tag), {busy, INT}, 2'b11);
        else          check($sformatf("%s back to idle", tag), {busy, INT}, 2'b00);
    endtask

    initial begin
        vec_t r, e;

        // sngl sp aeoi slaveReg slaveID vecBase cascIn flag id | isr cOE cOut dOE data eoi
        vecs[0] = mkVec(1, 1, 0, 8'h00, 3'd0, 5'h11, 3'd0, 1, 3'd3, 8'h08, 0, 3'd0, 1, 8'h8B, 8'h00);
        vecs[1] = mkVec(0, 1, 0, 8'h04, 3'd0, 5'h11, 3'd0, 1, 3'd2, 8'h04, 1, 3'd2, 0, 8'h00, 8'h00);
        vecs[2] = mkVec(0, 0, 0, 8'h00, 3'd5, 5'h08, 3'd5, 1, 3'd6, 8'h40, 0, 3'd0, 1, 8'h46, 8'h00);
        vecs[3] = mkVec(0, 0, 0, 8'h00, 3'd5, 5'h08, 3'd4, 1, 3'd6, 8'h40, 0, 3'd0, 0, 8'h00, 8'h00);
        vecs[4] = mkVec(1, 1, 1, 8'h00, 3'd0, 5'h11, 3'd0, 1, 3'd0, 8'h01, 0, 3'd0, 1, 8'h88, 8'h01);
        vecs[5] = mkVec(1, 1, 1, 8'h00, 3'd0, 5'h11, 3'd0, 0, 3'd0, 8'h00, 0, 3'd0, 1, 8'h8F, 8'h00);
        vecs[6] = mkVec(0, 1, 0, 8'h04, 3'd0, 5'h1F, 3'd0, 1, 3'd5, 8'h20, 0, 3'd0, 1, 8'hFD, 8'h00);
        vecs[7] = mkVec(0, 1, 1, 8'h81, 3'd0, 5'h00, 3'd0, 1, 3'd7, 8'h80, 1, 3'd7, 0, 8'h00, 8'h80);

        reset = 1'b1; INTA_n = 1'b1; SNGL = 1'b1; SP = 1'b1; AEOI = 1'b0;
        slaveReg = 0; slaveID = 0; vecBase = 0; intrFlag = 1'b0; intrID = 0; cascIn = 0;
        step(3);
        check("reset outputs", {INT, busy, dataOE, cascOE, cascOut, isrSet, eoiAuto, dataOut}, 0);
        reset = 1'b0;
        step(2);

        // INTA pulse while idle must be ignored.
        clearObs();
        INTA_n = 1'b0;
        step(2);
        INTA_n = 1'b1;
        step(SYNC + 4);
        check("idle INTA busy", busyCnt, 0);
        check("idle INTA isrSet", isrCnt, 0);
        check("idle INTA dataOE", dataOECnt, 0);

        for (int i = 0; i < 8; i++) begin
            doTxn(vecs[i], 1'b0);
            checkTxn(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            r = mkVec($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, 8'($urandom), 3'($urandom),
                      5'($urandom), 3'($urandom), $urandom_range(0, 4) != 0,
                      3'($urandom), 0, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 1) == 1) r.cascIn = r.slaveID;
            e = predict(r);
            doTxn(r, 1'b0);
            checkTxn(e, $sformatf("rand%0d", i), 1'b0);
        end

        // Unserved slave keeps its request: INT comes back after the sequence.
        doTxn(vecs[3], 1'b1);
        checkTxn(vecs[3], "unserved slave", 1'b1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        intrFlag = 1'b0;
        step(2);

        // Reset in ACK2 with the vector on the bus: outputs drop without a clock edge.
        SNGL = 1'b1; SP = 1'b1; AEOI = 1'b0; vecBase = 5'h11;
        intrFlag = 1'b1; intrID = 3'd1;
        step(2);
        INTA_n = 1'b0;
        step(2);
        INTA_n = 1'b1;
        step(SYNC + 3);
        intrFlag = 1'b0;
        INTA_n = 1'b0;
        for (int i = 0; i < 12 && !dataOE; i++) step(1);
        check("reset test dataOE reached", dataOE, 1);
        check("reset test dataOut", dataOut, 8'h89);
        #2 reset = 1'b1;
        #1;
        check("async reset outputs", {INT, busy, dataOE, cascOE, cascOut, isrSet, eoiAuto, dataOut}, 0);
        INTA_n = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
        doTxn(vecs[0], 1'b0);
        checkTxn(vecs[0], "after reset", 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
